// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// select codes and the decoded-instruction bundle passed from decoder to FSM.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BEQ  = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_JR   = 2'd3;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;

    localparam logic [1:0] A3_RT    = 2'd0;
    localparam logic [1:0] A3_RD    = 2'd1;
    localparam logic [1:0] A3_RA    = 2'd2;

    localparam logic [2:0] WD_ALU   = 3'd0;
    localparam logic [2:0] WD_MEM   = 3'd1;
    localparam logic [2:0] WD_PC4   = 3'd2;
    localparam logic [2:0] WD_MEMB  = 3'd3;

    localparam logic [1:0] BSEL_RT  = 2'd0;
    localparam logic [1:0] BSEL_EXT = 2'd1;

    typedef enum logic [2:0] {
        CL_ILL   = 3'd0,
        CL_ALU   = 3'd1,
        CL_LOAD  = 3'd2,
        CL_STORE = 3'd3,
        CL_BEQ   = 3'd4,
        CL_J     = 3'd5,
        CL_JAL   = 3'd6,
        CL_JR    = 3'd7
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [1:0] npc_op;
        logic [1:0] ext_op;
        logic [3:0] alu_op;
        logic [1:0] a3_sel;
        logic [2:0] wd_sel;
        logic [1:0] b_sel;
    } ctrl_t;

    function automatic logic is_mem_class(input iclass_e cls);
        return (cls == CL_LOAD) || (cls == CL_STORE);
    endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction decoder: classifies the IR word and produces the
// static datapath selects; sequencing is left to mips_mc_control.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];

    always_comb begin
        o_ctrl = '0;
        case (w_op)
            OP_RTYPE: begin
                o_ctrl.a3_sel = A3_RD;
                // Only the all-zero word (nop) is accepted from the shift group.
                if (i_instr == 32'h0000_0000) begin
                    o_ctrl.cls    = CL_ALU;
                    o_ctrl.alu_op = ALU_ADD;
                end else begin
                    case (w_fn)
                        FN_ADDU: begin
                            o_ctrl.cls    = CL_ALU;
                            o_ctrl.alu_op = ALU_ADD;
                        end
                        FN_SUBU: begin
                            o_ctrl.cls    = CL_ALU;
                            o_ctrl.alu_op = ALU_SUB;
                        end
                        FN_JR: begin
                            o_ctrl.cls    = CL_JR;
                            o_ctrl.npc_op = NPC_JR;
                            o_ctrl.a3_sel = A3_RT;
                        end
                        default: o_ctrl = '0;
                    endcase
                end
            end
            OP_ORI: begin
                o_ctrl.cls    = CL_ALU;
                o_ctrl.ext_op = EXT_ZERO;
                o_ctrl.alu_op = ALU_OR;
                o_ctrl.b_sel  = BSEL_EXT;
            end
            OP_LUI: begin
                o_ctrl.cls    = CL_ALU;
                o_ctrl.ext_op = EXT_LUI;
                o_ctrl.alu_op = ALU_ADD;
                o_ctrl.b_sel  = BSEL_EXT;
            end
            OP_LW, OP_LB, OP_SW: begin
                o_ctrl.cls    = (w_op == OP_SW) ? CL_STORE : CL_LOAD;
                o_ctrl.ext_op = EXT_SIGN;
                o_ctrl.alu_op = ALU_ADD;
                o_ctrl.b_sel  = BSEL_EXT;
                o_ctrl.wd_sel = (w_op == OP_LB) ? WD_MEMB : WD_MEM;
            end
            OP_BEQ: begin
                o_ctrl.cls    = CL_BEQ;
                o_ctrl.npc_op = NPC_BEQ;
                o_ctrl.ext_op = EXT_SIGN;
                o_ctrl.alu_op = ALU_SUB;
                o_ctrl.b_sel  = BSEL_RT;
            end
            OP_J: begin
                o_ctrl.cls    = CL_J;
                o_ctrl.npc_op = NPC_J;
            end
            OP_JAL: begin
                o_ctrl.cls    = CL_JAL;
                o_ctrl.npc_op = NPC_J;
                o_ctrl.a3_sel = A3_RA;
                o_ctrl.wd_sel = WD_PC4;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) with retire counter.
// Optional MC_MEM_WAIT_EN: honour mem_ready and time out stalled accesses.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MEM_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       NPCOp,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       EXTOp,
    output logic [3:0]       ALUOp,
    output logic [1:0]       RegA3Sel,
    output logic [2:0]       RegDataSel,
    output logic [1:0]       AluBSel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_done;
    logic             w_timeout;
    logic             w_sel_en;
    ctrl_t            w_ctrl;

    mips_mc_decode u_decode (
        .i_instr (instr),
        .o_ctrl  (w_ctrl)
    );

`ifdef MC_MEM_WAIT_EN
    localparam int unsigned WAIT_W = $clog2(MEM_WAIT + 1);

    logic [WAIT_W-1:0] r_wait;

    assign w_done    = mem_req && mem_ready;
    assign w_timeout = mem_req && !mem_ready && (r_wait == WAIT_W'(MEM_WAIT - 1));

    // Counts consecutive stalled cycles of the current access only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= '0;
        end else if (!mem_req || mem_ready || w_timeout) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    logic w_unused_ok;

    assign w_done      = mem_req;
    assign w_timeout   = 1'b0;
    assign w_unused_ok = &{1'b0, mem_ready, MEM_WAIT[0]};
`endif

    assign w_sel_en = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                      (r_state == ST_MEM)    || (r_state == ST_WB);

    assign NPCOp      = w_sel_en ? w_ctrl.npc_op : NPC_PC4;
    assign EXTOp      = w_sel_en ? w_ctrl.ext_op : EXT_ZERO;
    assign ALUOp      = w_sel_en ? w_ctrl.alu_op : ALU_ADD;
    assign RegA3Sel   = w_sel_en ? w_ctrl.a3_sel : A3_RT;
    assign RegDataSel = w_sel_en ? w_ctrl.wd_sel : WD_ALU;
    assign AluBSel    = w_sel_en ? w_ctrl.b_sel  : BSEL_RT;

    assign mem_req = (r_state == ST_FETCH) ||
                     ((r_state == ST_MEM) && is_mem_class(w_ctrl.cls));

    always_comb begin
        w_next   = r_state;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        illegal  = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                if (w_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = ST_DECODE;
                end else if (w_timeout) begin
                    illegal = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_ctrl.cls == CL_ILL) begin
                    illegal  = 1'b1;
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
                case (w_ctrl.cls)
                    CL_ALU:             w_next = ST_WB;
                    CL_LOAD, CL_STORE:  w_next = ST_MEM;
                    CL_BEQ: begin
                        PCWrite  = zero;
                        w_retire = 1'b1;
                    end
                    CL_J, CL_JR: begin
                        PCWrite  = 1'b1;
                        w_retire = 1'b1;
                    end
                    CL_JAL: begin
                        PCWrite  = 1'b1;
                        RegWrite = 1'b1;
                        w_retire = 1'b1;
                    end
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!is_mem_class(w_ctrl.cls)) begin
                    w_next = ST_FETCH;
                end else if (w_done) begin
                    if (w_ctrl.cls == CL_STORE) begin
                        MemWrite = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_timeout) begin
                    illegal = 1'b1;
                    w_next  = ST_FETCH;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                w_retire = 1'b1;
                w_next   = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control; the wait/timeout section runs only when
// MC_MEM_WAIT_EN is defined for the build.
module tb_mips_mc_control;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  NPCOp;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  EXTOp;
    logic [3:0]  ALUOp;
    logic [1:0]  RegA3Sel;
    logic [2:0]  RegDataSel;
    logic [1:0]  AluBSel;
    logic [2:0]  state;
    logic [31:0] retired;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    mips_mc_control #(.CNT_W(32), .MEM_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .NPCOp      (NPCOp),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .EXTOp      (EXTOp),
        .ALUOp      (ALUOp),
        .RegA3Sel   (RegA3Sel),
        .RegDataSel (RegDataSel),
        .AluBSel    (AluBSel),
        .state      (state),
        .retired    (retired),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        instr     = 32'h0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        chk("rst_retired", retired, 32'd0);

        reset = 1'b1;
        #1;
        chk("idle_after_release", {29'd0, state}, 32'd0);
        tick();
        chk("fetch_state", {29'd0, state}, 32'd1);
        chk("fetch_memreq", {31'd0, mem_req}, 32'd1);
        chk("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("fetch_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("fetch_npcop", {30'd0, NPCOp}, 32'd0);
        chk("fetch_retired", retired, 32'd0);

        // addu $3,$1,$2
        instr = 32'h0022_1821;
        tick();
        chk("addu_dec_state", {29'd0, state}, 32'd2);
        chk("addu_dec_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("addu_dec_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        chk("addu_exec_state", {29'd0, state}, 32'd3);
        tick();
        chk("addu_wb_state", {29'd0, state}, 32'd5);
        chk("addu_wb_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("addu_wb_a3sel", {30'd0, RegA3Sel}, 32'd1);
        chk("addu_wb_datasel", {29'd0, RegDataSel}, 32'd0);
        chk("addu_wb_retired", retired, 32'd0);
        tick();
        chk("addu_retired", retired, 32'd1);
        chk("addu_back_fetch", {29'd0, state}, 32'd1);

        // lb $5,-1($0)
        instr = 32'h8005_FFFF;
        tick();
        tick();
        chk("lb_exec_extop", {30'd0, EXTOp}, 32'd1);
        chk("lb_exec_bsel", {30'd0, AluBSel}, 32'd1);
        chk("lb_exec_aluop", {28'd0, ALUOp}, 32'd0);
        tick();
        chk("lb_mem_state", {29'd0, state}, 32'd4);
        chk("lb_mem_memreq", {31'd0, mem_req}, 32'd1);
        chk("lb_mem_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        chk("lb_wb_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("lb_wb_datasel", {29'd0, RegDataSel}, 32'd3);
        chk("lb_wb_a3sel", {30'd0, RegA3Sel}, 32'd0);
        tick();
        chk("lb_retired", retired, 32'd2);

        // beq not taken
        instr = 32'h1022_0003;
        zero  = 1'b0;
        tick();
        tick();
        chk("beq0_pcwrite", {31'd0, PCWrite}, 32'd0);
        chk("beq0_npcop", {30'd0, NPCOp}, 32'd1);
        tick();
        chk("beq0_retired", retired, 32'd3);
        chk("beq0_back_fetch", {29'd0, state}, 32'd1);

        // beq taken
        zero = 1'b1;
        tick();
        tick();
        chk("beq1_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("beq1_npcop", {30'd0, NPCOp}, 32'd1);
        tick();
        chk("beq1_retired", retired, 32'd4);
        zero = 1'b0;

        // jal
        instr = 32'h0C00_0010;
        tick();
        tick();
        chk("jal_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("jal_npcop", {30'd0, NPCOp}, 32'd2);
        chk("jal_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("jal_a3sel", {30'd0, RegA3Sel}, 32'd2);
        chk("jal_datasel", {29'd0, RegDataSel}, 32'd2);
        tick();
        chk("jal_retired", retired, 32'd5);

        // jr $31
        instr = 32'h03E0_0008;
        tick();
        tick();
        chk("jr_npcop", {30'd0, NPCOp}, 32'd3);
        chk("jr_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("jr_regwrite", {31'd0, RegWrite}, 32'd0);
        tick();
        chk("jr_retired", retired, 32'd6);

        // sw $5,4($0)
        instr = 32'hAC05_0004;
        tick();
        tick();
        chk("sw_exec_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        chk("sw_mem_memwrite", {31'd0, MemWrite}, 32'd1);
        chk("sw_mem_memreq", {31'd0, mem_req}, 32'd1);
        tick();
        chk("sw_retired", retired, 32'd7);
        chk("sw_back_fetch", {29'd0, state}, 32'd1);

        // opcode 0x3F
        instr = 32'hFC00_0000;
        tick();
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("ill_memwrite", {31'd0, MemWrite}, 32'd0);
        tick();
        chk("ill_back_fetch", {29'd0, state}, 32'd1);
        chk("ill_pulse_gone", {31'd0, illegal}, 32'd0);
        chk("ill_retired", retired, 32'd8);

        // nop
        instr = 32'h0000_0000;
        tick();
        chk("nop_legal", {31'd0, illegal}, 32'd0);
        tick();
        tick();
        chk("nop_wb_regwrite", {31'd0, RegWrite}, 32'd1);
        tick();
        chk("nop_retired", retired, 32'd9);

        // ori $2,$1,5
        instr = 32'h3422_0005;
        tick();
        tick();
        chk("ori_aluop", {28'd0, ALUOp}, 32'd2);
        chk("ori_extop", {30'd0, EXTOp}, 32'd0);
        chk("ori_bsel", {30'd0, AluBSel}, 32'd1);
        tick();
        chk("ori_wb_a3sel", {30'd0, RegA3Sel}, 32'd0);
        tick();
        chk("ori_retired", retired, 32'd10);

        // reset asserted in the middle of an addu
        instr = 32'h0022_1821;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("midrst_memreq", {31'd0, mem_req}, 32'd0);
        chk("midrst_retired", retired, 32'd0);
        tick();
        chk("midrst_hold_idle", {29'd0, state}, 32'd0);

`ifdef MC_MEM_WAIT_EN
        @(negedge clk);
        reset = 1'b1;
        instr = 32'hAC05_0004;
        tick();
        chk("w_fetch", {29'd0, state}, 32'd1);
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("w_mem_state", {29'd0, state}, 32'd4);
        chk("w_memwrite_0", {31'd0, MemWrite}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("w_mem_hold", {29'd0, state}, 32'd4);
            chk("w_memwrite_hold", {31'd0, MemWrite}, 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("w_memwrite_ready", {31'd0, MemWrite}, 32'd1);
        tick();
        mem_ready = 1'b0;
        chk("w_sw_retired", retired, 32'd1);
        #1;
        chk("w_fetch_irwrite", {31'd0, IRWrite}, 32'd0);
        tick();
        chk("w_fetch_hold", {29'd0, state}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("w_midwait_rst", {29'd0, state}, 32'd0);
        chk("w_midwait_memreq", {31'd0, mem_req}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
